// File: rtl/lanes_deserializer_if.sv
// Parallel-side and serial-side bundle for the two-lane RX deserializer.
// The master modport drives the serial lanes; the slave modport is the deserializer.
interface lanes_deserializer_if #(
    parameter int WIDTH = 132
);
    logic             enable_deser;
    logic [1:0]       gen_speed;
    logic             lane_0_rx_ser;
    logic             lane_1_rx_ser;
    logic             bit_slip;
    logic [WIDTH-1:0] lane_0_rx_parallel;
    logic [WIDTH-1:0] lane_1_rx_parallel;
    logic             rx_word_valid;
    logic             descr_rst;
    logic             enable_descr;

    modport master (
        output enable_deser,
        output gen_speed,
        output lane_0_rx_ser,
        output lane_1_rx_ser,
        output bit_slip,
        input  lane_0_rx_parallel,
        input  lane_1_rx_parallel,
        input  rx_word_valid,
        input  descr_rst,
        input  enable_descr
    );

    modport slave (
        input  enable_deser,
        input  gen_speed,
        input  lane_0_rx_ser,
        input  lane_1_rx_ser,
        input  bit_slip,
        output lane_0_rx_parallel,
        output lane_1_rx_parallel,
        output rx_word_valid,
        output descr_rst,
        output enable_descr
    );
endinterface

// File: rtl/lanes_deserializer.sv
// Two-lane RX deserializer: LSB-first word assembly, word length set by gen speed.
// Optional word-boundary slip is compiled in with `define RX_BIT_SLIP_EN.
//
// state   | meaning
// S_IDLE  | enable_deser low; counter and shift registers cleared, buses hold
// S_SHIFT | sampling one bit per clock on both lanes into the shared word
module lanes_deserializer #(
    parameter int WIDTH = 132
) (
    input  logic                 clk,
    input  logic                 rst,
    lanes_deserializer_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [7:0]       r_cnt;
    logic [7:0]       r_n;
    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_par0;
    logic [WIDTH-1:0] r_par1;
    logic             r_valid;
    logic             r_descr_rst;
    logic             r_en_descr;

    logic [7:0]       w_n_start;
    logic [7:0]       w_n_cur;
    logic [7:0]       w_idx;
    logic             w_sample;
    logic             w_complete;
    logic             w_slip;
    logic [WIDTH-1:0] w_sh0_next;
    logic [WIDTH-1:0] w_sh1_next;

    always_comb begin
        case (bus.gen_speed)
            2'b01:   w_n_start = 8'd132;
            2'b10:   w_n_start = 8'd66;
            default: w_n_start = 8'd8;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The IDLE->SHIFT edge already samples bit 0 using the freshly decoded length.
    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_complete   = 1'b0;
        w_slip       = 1'b0;
        w_idx        = r_cnt;
        w_n_cur      = r_n;
        case (r_state)
            S_IDLE: begin
                if (bus.enable_deser) begin
                    w_state_next = S_SHIFT;
                    w_sample     = 1'b1;
                    w_idx        = 8'd0;
                    w_n_cur      = w_n_start;
                end
            end
            S_SHIFT: begin
                if (!bus.enable_deser) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_sample = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_sample) begin
            w_complete = (w_idx == (w_n_cur - 8'd1));
`ifdef RX_BIT_SLIP_EN
            // A completing sample wins over a slip request.
            w_slip = (r_state == S_SHIFT) && bus.bit_slip && !w_complete;
`endif
        end
    end

`ifndef RX_BIT_SLIP_EN
    logic w_unused_bit_slip;
    assign w_unused_bit_slip = bus.bit_slip;
`endif

    // Bit 0 of a word clears the stale upper bits so bits [WIDTH-1:N] read as 0.
    always_comb begin
        w_sh0_next        = (w_idx == 8'd0) ? '0 : r_sh0;
        w_sh1_next        = (w_idx == 8'd0) ? '0 : r_sh1;
        w_sh0_next[w_idx] = bus.lane_0_rx_ser;
        w_sh1_next[w_idx] = bus.lane_1_rx_ser;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 8'd0;
            r_n         <= 8'd8;
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_par0      <= '0;
            r_par1      <= '0;
            r_valid     <= 1'b0;
            r_descr_rst <= 1'b0;
            r_en_descr  <= 1'b0;
        end else if (w_state_next == S_IDLE) begin
            r_cnt       <= 8'd0;
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_valid     <= 1'b0;
            r_descr_rst <= 1'b0;
            r_en_descr  <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_n <= w_n_start;
            end
            r_valid     <= w_complete;
            r_descr_rst <= w_complete;
            if (!w_slip) begin
                r_sh0 <= w_sh0_next;
                r_sh1 <= w_sh1_next;
            end
            if (w_complete) begin
                r_par0     <= w_sh0_next;
                r_par1     <= w_sh1_next;
                r_en_descr <= 1'b1;
                r_cnt      <= 8'd0;
            end else if (!w_slip) begin
                r_cnt <= w_idx + 8'd1;
            end
        end
    end

    assign bus.lane_0_rx_parallel = r_par0;
    assign bus.lane_1_rx_parallel = r_par1;
    assign bus.rx_word_valid      = r_valid;
    assign bus.descr_rst          = r_descr_rst;
    assign bus.enable_descr       = r_en_descr;

endmodule

// File: tb/tb_lanes_deserializer.sv
// Bench for lanes_deserializer: directed scenarios plus random traffic,
// every cycle compared against a queue-based word-assembly model.
module tb_lanes_deserializer;

    localparam int W = 132;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lanes_deserializer_if #(.WIDTH(W)) bus ();

    lanes_deserializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit         m_active = 1'b0;
    int         m_n      = 8;
    bit         q0[$];
    bit         q1[$];
    logic [W-1:0] m_par0 = '0;
    logic [W-1:0] m_par1 = '0;
    bit         m_valid  = 1'b0;
    bit         m_descr  = 1'b0;
    bit         m_en     = 1'b0;

    int cyc         = 0;
    int n_strobes   = 0;
    int last_strobe = 0;
    int strobe_gap  = 0;
    int first_strobe = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input bit q[$]);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < q.size(); k++) w[k] = q[k];
        return w;
    endfunction

    task automatic model_edge(input bit en, input bit [1:0] gs, input bit b0, input bit b1,
                              input bit slip, input bit r);
        m_valid = 1'b0;
        m_descr = 1'b0;
        if (r) begin
            m_active = 1'b0; q0.delete(); q1.delete();
            m_par0 = '0; m_par1 = '0; m_en = 1'b0;
            return;
        end
        if (!en) begin
            m_active = 1'b0; q0.delete(); q1.delete(); m_en = 1'b0;
            return;
        end
        if (!m_active) begin
            m_active = 1'b1;
            m_n = (gs == 2'b01) ? 132 : (gs == 2'b10) ? 66 : 8;
        end else begin
`ifdef RX_BIT_SLIP_EN
            if (slip && (q0.size() != m_n - 1)) return;
`endif
        end
        q0.push_back(b0);
        q1.push_back(b1);
        if (q0.size() == m_n) begin
            m_par0 = pack(q0);
            m_par1 = pack(q1);
            m_valid = 1'b1; m_descr = 1'b1; m_en = 1'b1;
            q0.delete(); q1.delete();
        end
    endtask

    task automatic step(input bit en, input bit [1:0] gs, input bit b0, input bit b1,
                        input bit slip, input bit r);
        bus.enable_deser  = en;
        bus.gen_speed     = gs;
        bus.lane_0_rx_ser = b0;
        bus.lane_1_rx_ser = b1;
        bus.bit_slip      = slip;
        rst               = r;
        @(posedge clk);
        model_edge(en, gs, b0, b1, slip, r);
        @(negedge clk);
        cyc++;
        chk("par0",  bus.lane_0_rx_parallel, m_par0);
        chk("par1",  bus.lane_1_rx_parallel, m_par1);
        chk("valid", bus.rx_word_valid, m_valid);
        chk("descr", bus.descr_rst, m_descr);
        chk("en_de", bus.enable_descr, m_en);
        if (bus.rx_word_valid === 1'b1) begin
            n_strobes++;
            strobe_gap  = cyc - last_strobe;
            last_strobe = cyc;
            if (n_strobes == 1) first_strobe = cyc;
        end
    endtask

    task automatic clear_counts();
        n_strobes = 0; strobe_gap = 0; first_strobe = 0; last_strobe = cyc;
    endtask

    initial begin
        logic [7:0] a0, a1, p0, p1;
        int base;

        bus.enable_deser = 1'b0; bus.gen_speed = 2'b00;
        bus.lane_0_rx_ser = 1'b0; bus.lane_1_rx_ser = 1'b0; bus.bit_slip = 1'b0;

        // reset state
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_par0", bus.lane_0_rx_parallel, '0);
        chk("rst_valid", bus.rx_word_valid, 1'b0);

        // GEN4 single word
        a0 = 8'hA5; a1 = 8'hF0;
        clear_counts();
        for (int i = 0; i < 8; i++) step(1'b1, 2'b00, a0[i], a1[i], 1'b0, 1'b0);
        chk("gen4_par0", bus.lane_0_rx_parallel, 8'hA5);
        chk("gen4_par1", bus.lane_1_rx_parallel, 8'hF0);
        chk("gen4_valid", bus.rx_word_valid, 1'b1);
        chk("gen4_descr", bus.descr_rst, 1'b1);
        chk("gen4_en", bus.enable_descr, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("gen4_valid_drop", bus.rx_word_valid, 1'b0);
        chk("gen4_hold", bus.lane_0_rx_parallel, 8'hA5);

        // GEN2 back-to-back
        clear_counts();
        for (int i = 0; i < 132; i++)
            step(1'b1, 2'b10, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        chk("gen2_strobes", n_strobes, 2);
        chk("gen2_gap", strobe_gap, 66);
        chk("gen2_upper", bus.lane_0_rx_parallel >> 66, '0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // GEN3 with gen_speed change at cycle 50
        clear_counts();
        base = cyc;
        for (int i = 0; i < 140; i++)
            step(1'b1, (i < 50) ? 2'b01 : 2'b00, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        chk("gen3_strobes", n_strobes, 1);
        chk("gen3_first", first_strobe - base, 132);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // enable drop mid-word
        clear_counts();
        for (int i = 0; i < 5; i++) step(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_en", bus.enable_descr, 1'b0);
        chk("drop_strobes", n_strobes, 0);
        p0 = 8'h3C; p1 = 8'hC3;
        for (int i = 0; i < 8; i++) step(1'b1, 2'b00, p0[i], p1[i], 1'b0, 1'b0);
        chk("drop_par0", bus.lane_0_rx_parallel, 8'h3C);
        chk("drop_par1", bus.lane_1_rx_parallel, 8'hC3);
        chk("drop_strobes2", n_strobes, 1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-word
        for (int i = 0; i < 30; i++) step(1'b1, 2'b10, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("mrst_par0", bus.lane_0_rx_parallel, '0);
        chk("mrst_par1", bus.lane_1_rx_parallel, '0);
        chk("mrst_en", bus.enable_descr, 1'b0);
        clear_counts();
        base = cyc;
        for (int i = 0; i < 66; i++) step(1'b1, 2'b10, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        chk("mrst_strobes", n_strobes, 1);
        chk("mrst_first", first_strobe - base, 66);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // bit slip: one word, then a junk 1 with slip, then 0xA5
        for (int i = 0; i < 8; i++) step(1'b1, 2'b00, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b00, a0[i], a0[i], 1'b0, 1'b0);
`ifdef RX_BIT_SLIP_EN
        chk("slip_par0", bus.lane_0_rx_parallel, 8'hA5);
`else
        chk("slip_par0", bus.lane_0_rx_parallel, 8'h4B);
`endif
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) != 0, 2'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 299) == 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lanes_deserializer.md
Name: lanes_deserializer

Overview:
- Receive-side counterpart of the lane serializer: samples one serial bit per clock on each of lane 0 and lane 1.
- Assembles each lane's bits LSB-first into parallel words. Word length depends on gen speed: GEN4 8 bits, GEN3 132 bits, GEN2 66 bits.
- Sits between the electrical-layer RX bit stream and the descrambler/decoder.
- Raises a one-cycle word strobe and a descrambler seed-reset pulse at each word boundary.

Parameters:
- WIDTH, 132: width of the parallel output buses; must be >= 132.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset. Synchronous, active-high.
- enable_deser  input  1  high = sample the serial lanes; low = idle and clear.
- gen_speed  input  2  2'b00 GEN4 (N=8), 2'b01 GEN3 (N=132), 2'b10 GEN2 (N=66), 2'b11 treated as GEN4.
- lane_0_rx_ser  input  1  lane 0 serial bit.
- lane_1_rx_ser  input  1  lane 1 serial bit.
- bit_slip  input  1  alignment request; used only when RX_BIT_SLIP_EN is defined.
- lane_0_rx_parallel  output  WIDTH  last completed lane 0 word.
- lane_1_rx_parallel  output  WIDTH  last completed lane 1 word.
- rx_word_valid  output  1  one-cycle strobe: new words on both parallel buses.
- descr_rst  output  1  one-cycle pulse, coincident with rx_word_valid; resets the descrambler seed.
- enable_descr  output  1  high while a word has been delivered and deserialization continues.

Behaviour:
- Reset (rst=1 at a rising edge): all outputs 0, shift registers 0, bit counter 0, state IDLE. Reset has priority over every other input.
- States:
  - IDLE: enable_deser=0.
  - SHIFT: enable_deser=1.
  - IDLE -> SHIFT on the first edge with enable_deser=1. That edge samples bit 0 of the first word.
  - Any edge with enable_deser=0 -> IDLE: counter 0, shift registers 0, rx_word_valid/descr_rst/enable_descr 0. The parallel buses hold their last value.
- gen_speed latches into an internal N register on the IDLE->SHIFT edge. Changes while in SHIFT are ignored until the next IDLE->SHIFT.
- Bit order: the k-th bit sampled in a word (k = 0..N-1) becomes bit k of the output word.
  - Output bits [WIDTH-1:N] are 0.
  - Both lanes share one counter and are always word-aligned to each other.
- Counter: counts 0..N-1, increments per sampled bit, wraps to 0 after N-1.
- Completion: on the edge that samples bit N-1:
  - both parallel buses load the assembled words;
  - rx_word_valid=1 and descr_rst=1 for exactly the following cycle;
  - enable_descr goes to 1 and stays 1 until IDLE or reset.
  - Latency: the last bit is visible on the bus one cycle after it is present on the serial input.
- Back-to-back words: the bit after bit N-1 is bit 0 of the next word. There is no gap cycle; strobes are spaced exactly N cycles apart.
- Reset mid-word: the partial word is discarded and no strobe is produced.
- enable_deser deasserted on the same edge as completion: IDLE wins, no strobe, buses are not updated.

Optional Feature:
- Macro: RX_BIT_SLIP_EN.
- Defined:
  - A bit_slip=1 sample in SHIFT holds the counter for that cycle; the sampled bit is discarded on both lanes. This shifts the word boundary one bit later.
  - bit_slip is ignored on the cycle where the counter would complete a word. The completion takes precedence and the slip is lost.
  - bit_slip in IDLE is ignored.
- Undefined: the bit_slip port exists but is unused. Boundaries are fixed by the IDLE->SHIFT edge only.

Test Plan:
- GEN4 single word:
  - Stimulus: reset, gen_speed=00, enable_deser=1, lane0 bits 1,0,1,0,0,1,0,1; lane1 bits 0,0,0,0,1,1,1,1.
  - Response: after 8 samples, lane_0_rx_parallel=0xA5 and lane_1_rx_parallel=0xF0. rx_word_valid and descr_rst are high for one cycle; enable_descr=1.
- GEN2 back-to-back:
  - Stimulus: 132 cycles of a known random stream, gen_speed=10.
  - Response: exactly two strobes, 66 cycles apart. Words match bits 0..65 and 66..131; bits [131:66] of each output are 0.
- GEN3 with gen_speed change:
  - Stimulus: start with gen_speed=01; switch to 00 at cycle 50.
  - Response: first strobe after sample 132; no strobe at 8 or 56.
- Enable drop mid-word:
  - Stimulus: GEN4, enable_deser low after 5 bits, then high again.
  - Response: no strobe; the next word is built from the 8 bits after re-enable; enable_descr returns to 0 while low.
- Reset mid-word:
  - Stimulus: GEN2, rst=1 at bit 30.
  - Response: all outputs 0 on the next cycle; the first strobe comes 66 samples after re-enable.
- RX_BIT_SLIP_EN:
  - Stimulus: GEN4, stream 0xA5 preceded by one junk bit, bit_slip=1 on the junk cycle.
  - Response: output 0xA5. With the macro undefined, the output is the misaligned value 0x4B from the same stream.
